// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-anode seven-segment driver.
// Scans NUM_DIGITS digits, one per REFRESH_DIV-cycle slot, with the first
// GUARD cycles of every slot blanked to suppress ghosting. Display data is
// double-buffered: loads land in a pending buffer that becomes active only
// when the scan wraps from the last digit back to digit 0.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   digits               nibble i drives digit i (digit 0 rightmost)
//   dp, blank            per-digit decimal point / blank (1 = dp lit / dark)
//   hex_mode             1 = hex decode, 0 = BCD decode (nibbles > 9 show dash)
//   load                 one-cycle strobe capturing digits/dp/blank/hex_mode
//   seg                  bit 7 = dp, bits 6:0 = g..a (polarity per SEG_ACTIVE_LOW)
//   anode                one-hot digit enable (polarity per AN_ACTIVE_LOW)
//   scan_idx             digit currently driven
//   frame_done           one-cycle pulse after the scan wraps to digit 0
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    hex_mode,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [2:0]              scan_idx,
  output logic                    frame_done
);

  localparam int                   PCW      = $clog2(REFRESH_DIV);
  localparam logic [PCW-1:0]        PC_LAST  = PCW'(REFRESH_DIV - 1);
  localparam logic [PCW-1:0]        PC_GUARD = PCW'(GUARD);
  localparam logic [2:0]            IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    hex;
  } disp_t;

  logic [PCW-1:0] pc;
  logic [2:0]     idx;
  disp_t          act;
  disp_t          pend;
  disp_t          in_buf;
  logic           pend_valid;
  logic           slot_end;
  logic           wrap;

  assign in_buf   = '{digits: digits, dp: dp, blank: blank, hex: hex_mode};
  assign slot_end = (pc == PC_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else if (slot_end) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      pc <= pc + PCW'(1);
    end
  end

  // Double buffer: a load on the wrap cycle bypasses pending so it shows in
  // the very next frame; otherwise the last load before the wrap wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
      if (load) begin
        act <= in_buf;
      end else if (pend_valid) begin
        act <= pend;
      end
    end else if (load) begin
      pend       <= in_buf;
      pend_valid <= 1'b1;
    end
  end

  // Digit select and decode
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            pat;
  logic                  lit;
  logic [7:0]            seg_int;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_comb begin
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        nib       = act.digits[4*i +: 4];
        cur_dp    = act.dp[i];
        cur_blank = act.blank[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pat = 7'h40;
    if (!act.hex && nib > 4'd9) begin
      pat = 7'h40;
    end else begin
      case (nib)
        4'h0: pat = 7'h3F;
        4'h1: pat = 7'h06;
        4'h2: pat = 7'h5B;
        4'h3: pat = 7'h4F;
        4'h4: pat = 7'h66;
        4'h5: pat = 7'h6D;
        4'h6: pat = 7'h7D;
        4'h7: pat = 7'h07;
        4'h8: pat = 7'h7F;
        4'h9: pat = 7'h6F;
        4'hA: pat = 7'h77;
        4'hB: pat = 7'h7C;
        4'hC: pat = 7'h39;
        4'hD: pat = 7'h5E;
        4'hE: pat = 7'h79;
        4'hF: pat = 7'h71;
        default: pat = 7'h40;
      endcase
    end
  end

  always_comb begin
    lit     = (pc >= PC_GUARD) && !cur_blank;
    seg_int = lit ? {cur_dp, pat} : 8'h00;
    an_d    = lit ? onehot : '0;
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_int : seg_int;
    if (AN_ACTIVE_LOW != 0) begin
      an_d = ~an_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      anode      <= AN_OFF;
      scan_idx   <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      anode      <= an_d;
      scan_idx   <= idx;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for seven_seg_scan with NUM_DIGITS=4,
// REFRESH_DIV=4, GUARD=1, active-low segments and anodes. Expected segment
// codes per digit are written out by hand for each load.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        hex_mode;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic [2:0]  scan_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .GUARD         (1),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .dp        (dp),
    .blank     (blank),
    .hex_mode  (hex_mode),
    .load      (load),
    .seg       (seg),
    .anode     (anode),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Position within the 16-cycle frame that the next sample reflects
  // (pc + 4*idx of the previous cycle).
  int          k_next;
  // Expected active / pending display: packed seg codes {d3,d2,d1,d0}.
  logic [31:0] m_seg;
  logic [3:0]  m_bl;
  logic [31:0] p_seg;
  logic [3:0]  p_bl;
  logic        m_pv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int         k;
    int         d;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    @(negedge clk);
    k = k_next;
    d = k / 4;
    if ((k % 4) == 0 || m_bl[d]) begin
      an_e  = 4'hF;
      seg_e = 8'hFF;
    end else begin
      an_e  = ~(4'b0001 << d);
      seg_e = m_seg[d*8 +: 8];
    end
    check($sformatf("anode k=%0d", k), 32'(anode), 32'(an_e));
    check($sformatf("seg k=%0d", k), 32'(seg), 32'(seg_e));
    check($sformatf("scan_idx k=%0d", k), 32'(scan_idx), 32'(d));
    check($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(k == 15));
    if (k == 15 && m_pv) begin
      m_seg = p_seg;
      m_bl  = p_bl;
      m_pv  = 1'b0;
    end
    k_next = (k + 1) % 16;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until(input int k);
    for (int i = 0; i < 16 && k_next != k; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic h, input logic [31:0] es, input logic [3:0] eb);
    digits   = d;
    dp       = p;
    blank    = b;
    hex_mode = h;
    load     = 1'b1;
    p_seg    = es;
    p_bl     = eb;
    m_pv     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic reset_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check("rst anode", 32'(anode), 32'h0000000F);
      check("rst seg", 32'(seg), 32'h000000FF);
      check("rst scan_idx", 32'(scan_idx), 32'd0);
      check("rst frame_done", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic model_reset();
    m_seg  = {4{8'hC0}};
    m_bl   = 4'h0;
    m_pv   = 1'b0;
    k_next = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    digits   = '0;
    dp       = '0;
    blank    = '0;
    hex_mode = 1'b0;
    load     = 1'b0;
    p_seg    = '0;
    p_bl     = '0;
    model_reset();

    // Reset, then a frame of zeros; first active anode on the pc=1 sample
    reset_check(3);
    rst_n = 1'b1;
    run(16);

    // BCD digits 1234
    do_load(16'h1234, 4'h0, 4'h0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'h0);
    run_until(0);
    run(16);

    // BCD nibbles above 9 show a dash
    do_load(16'hAF90, 4'h0, 4'h0, 1'b0, {8'hBF, 8'hBF, 8'h90, 8'hC0}, 4'h0);
    run_until(0);
    run(16);

    // Hex decode, dp on digit 0, digit 1 blanked
    do_load(16'hAF90, 4'h1, 4'h2, 1'b1, {8'h88, 8'h8E, 8'h90, 8'h40}, 4'h2);
    run_until(0);
    run(16);

    // Two loads mid-frame: the current frame is untouched, the later one wins
    run(5);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0, {4{8'hF9}}, 4'h0);
    run(1);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0, {4{8'hA4}}, 4'h0);
    run_until(0);
    run(16);

    // Pending load earlier in the frame, then a load on the wrap cycle:
    // the wrap-cycle data shows and stays; the earlier data never appears.
    run_until(5);
    do_load(16'h1234, 4'h0, 4'h0, 1'b0, {4{8'h92}}, 4'h0);
    run_until(15);
    do_load(16'h5555, 4'h0, 4'h0, 1'b0, {4{8'h92}}, 4'h0);
    run(32);

    // Reset mid-scan discards a pending load
    run_until(8);
    do_load(16'h8888, 4'h0, 4'h0, 1'b0, {4{8'h80}}, 4'h0);
    run(1);
    rst_n = 1'b0;
    reset_check(3);
    model_reset();
    rst_n = 1'b1;
    run(32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
